// File: rtl/can_tx_scheduler.sv
// Transmit scheduler: picks the pending mailbox with the lowest 11-bit ID, sequences the frame
// through the CAN node, retries errored frames and enforces an inter-frame gap.
module can_tx_scheduler #(
  parameter int NUM_MB     = 4,
  parameter int MAX_RETRY  = 3,
  parameter int IFS_CYCLES = 3
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [NUM_MB-1:0]         mb_req,
  input  logic [11*NUM_MB-1:0]      mb_id,
  input  logic [4*NUM_MB-1:0]       mb_dlc,
  input  logic [64*NUM_MB-1:0]      mb_data,
  output logic [NUM_MB-1:0]         mb_ack,
  output logic [NUM_MB-1:0]         mb_fail,
  input  logic                      bus_idle,
  input  logic                      tx_done,
  input  logic                      tx_arb_lost,
  input  logic                      tx_err,
  output logic                      tx_start,
  output logic [10:0]               tx_id,
  output logic [3:0]                tx_dlc,
  output logic [63:0]               tx_data,
  output logic [$clog2(NUM_MB)-1:0] cur_mb,
  output logic                      sched_busy
);

  localparam int MBW = $clog2(NUM_MB);
  localparam int RW  = $clog2(MAX_RETRY + 2);
  localparam int GW  = $clog2(IFS_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_START,
    S_WAIT,
    S_GAP
  } state_t;

  state_t              r_state;
  logic [NUM_MB-1:0]   r_ack;
  logic [NUM_MB-1:0]   r_fail;
  logic                r_tx_start;
  logic [10:0]         r_tx_id;
  logic [3:0]          r_tx_dlc;
  logic [63:0]         r_tx_data;
  logic [MBW-1:0]      r_cur_mb;
  logic                r_busy;
  logic [RW-1:0]       r_retry;
  logic [GW-1:0]       r_gap;

  logic                w_win_valid;
  logic [MBW-1:0]      w_win_idx;
  logic [10:0]         w_win_id;
  logic [3:0]          w_win_dlc;
  logic [63:0]         w_win_data;

  // Ascending scan with strict less-than leaves ID ties to the lowest index.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_idx   = '0;
    w_win_id    = '1;
    w_win_dlc   = '0;
    w_win_data  = '0;
    for (int unsigned i = 0; i < NUM_MB; i++) begin
      if (mb_req[i] && (!w_win_valid || (mb_id[11*i +: 11] < w_win_id))) begin
        w_win_valid = 1'b1;
        w_win_idx   = MBW'(i);
        w_win_id    = mb_id[11*i +: 11];
        w_win_dlc   = mb_dlc[4*i +: 4];
        w_win_data  = mb_data[64*i +: 64];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_ack      <= '0;
      r_fail     <= '0;
      r_tx_start <= 1'b0;
      r_tx_id    <= '0;
      r_tx_dlc   <= '0;
      r_tx_data  <= '0;
      r_cur_mb   <= '0;
      r_busy     <= 1'b0;
      r_retry    <= '0;
      r_gap      <= '0;
    end else begin
      r_tx_start <= 1'b0;
      r_ack      <= '0;
      r_fail     <= '0;
      unique case (r_state)
        S_IDLE: begin
          if ((|mb_req) && bus_idle) begin
            r_state <= S_SELECT;
            r_busy  <= 1'b1;
          end
        end
        S_SELECT: begin
          if (w_win_valid) begin
            r_tx_id    <= w_win_id;
            r_tx_dlc   <= w_win_dlc;
            r_tx_data  <= w_win_data;
            r_cur_mb   <= w_win_idx;
            if (w_win_idx != r_cur_mb) r_retry <= '0;
            r_tx_start <= 1'b1;
            r_state    <= S_START;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_START: r_state <= S_WAIT;
        S_WAIT: begin
          if (tx_done) begin
            r_ack[r_cur_mb] <= 1'b1;
            r_retry         <= '0;
            r_gap           <= '0;
            r_state         <= S_GAP;
          end else if (tx_err) begin
            if (r_retry < RW'(MAX_RETRY)) begin
              r_retry <= r_retry + 1'b1;
            end else begin
              r_fail[r_cur_mb] <= 1'b1;
              r_retry          <= '0;
            end
            r_gap   <= '0;
            r_state <= S_GAP;
          end else if (tx_arb_lost) begin
            r_gap   <= '0;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_gap == GW'(IFS_CYCLES - 1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mb_ack     = r_ack;
  assign mb_fail    = r_fail;
  assign tx_start   = r_tx_start;
  assign tx_id      = r_tx_id;
  assign tx_dlc     = r_tx_dlc;
  assign tx_data    = r_tx_data;
  assign cur_mb     = r_cur_mb;
  assign sched_busy = r_busy;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Bench for can_tx_scheduler: reset/timing sequences, a priority vector table and a randomized
// run checked against a transaction-level model of the scheduling rules.
module tb_can_tx_scheduler;

  localparam int NMB  = 4;
  localparam int MAXR = 3;
  localparam int IFS  = 3;

  logic                 CLK = 1'b0;
  logic                 RST_N;
  logic [NMB-1:0]       mb_req;
  logic [NMB-1:0][10:0] id_a;
  logic [NMB-1:0][3:0]  dlc_a;
  logic [NMB-1:0][63:0] data_a;
  logic [NMB-1:0]       mb_ack, mb_fail;
  logic                 bus_idle, tx_done, tx_arb_lost, tx_err;
  logic                 tx_start;
  logic [10:0]          tx_id;
  logic [3:0]           tx_dlc;
  logic [63:0]          tx_data;
  logic [1:0]           cur_mb;
  logic                 sched_busy;

  int checks = 0;
  int errors = 0;

  can_tx_scheduler #(.NUM_MB(NMB), .MAX_RETRY(MAXR), .IFS_CYCLES(IFS)) dut (
    .CLK(CLK), .RST_N(RST_N), .mb_req(mb_req), .mb_id(id_a), .mb_dlc(dlc_a),
    .mb_data(data_a), .mb_ack(mb_ack), .mb_fail(mb_fail), .bus_idle(bus_idle),
    .tx_done(tx_done), .tx_arb_lost(tx_arb_lost), .tx_err(tx_err), .tx_start(tx_start),
    .tx_id(tx_id), .tx_dlc(tx_dlc), .tx_data(tx_data), .cur_mb(cur_mb),
    .sched_busy(sched_busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]       req;
    logic [3:0][10:0] id;
    logic [3:0][2:0]  order;
    int               n;
  } vec_t;

  vec_t tbl [5];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_start(input string nm, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (tx_start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s tx_start timeout actual=0 expected=1", nm);
    end
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (!sched_busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s idle timeout actual=busy expected=idle", nm);
    end
  endtask

  // Called in the START cycle; moves into WAIT, optionally lingers, then raises the node events.
  task automatic ev(input bit d, input bit e, input bit a, input logic [3:0] eack,
                    input logic [3:0] efail, input int dly, input string nm);
    tick();
    for (int k = 0; k < dly; k++) tick();
    tx_done = d; tx_err = e; tx_arb_lost = a;
    tick();
    tx_done = 1'b0; tx_err = 1'b0; tx_arb_lost = 1'b0;
    chk({nm, " ack"}, 64'(mb_ack), 64'(eack));
    chk({nm, " fail"}, 64'(mb_fail), 64'(efail));
    mb_req = mb_req & ~(eack | efail);
    tick();
    chk({nm, " pulse width"}, 64'({mb_ack, mb_fail}), 64'd0);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
    tick();
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, " tx_start"}, 64'(tx_start), 64'd0);
    chk({nm, " tx_id"}, 64'(tx_id), 64'd0);
    chk({nm, " tx_dlc"}, 64'(tx_dlc), 64'd0);
    chk({nm, " tx_data"}, tx_data, 64'd0);
    chk({nm, " cur_mb"}, 64'(cur_mb), 64'd0);
    chk({nm, " busy"}, 64'(sched_busy), 64'd0);
    chk({nm, " ack"}, 64'(mb_ack), 64'd0);
    chk({nm, " fail"}, 64'(mb_fail), 64'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    bit ok;
    int starts;
    int last_mb, errs, w;
    int best;
    logic [3:0] eack, efail;
    bit d, e, a;

    RST_N = 1'b0; mb_req = '0; bus_idle = 1'b1;
    tx_done = 1'b0; tx_err = 1'b0; tx_arb_lost = 1'b0;
    id_a = '0; dlc_a = '0; data_a = '0;
    for (int i = 0; i < NMB; i++) begin
      dlc_a[i]  = 4'(i + 5);
      data_a[i] = {32'hC0DE_0000 + 32'(i), 32'h1234_5678 ^ 32'(i * 7)};
    end

    // Reset state
    tick(); tick();
    chk_zero_outputs("reset");
    RST_N = 1'b1;
    tick();

    // Single request with exact latency and gap length
    id_a[2] = 11'h123; dlc_a[2] = 4'd8; data_a[2] = 64'h0011_2233_4455_6677;
    mb_req = 4'b0100;
    tick();
    chk("single no early start", 64'(tx_start), 64'd0);
    tick();
    chk("single tx_start", 64'(tx_start), 64'd1);
    chk("single cur_mb", 64'(cur_mb), 64'd2);
    chk("single tx_id", 64'(tx_id), 64'h123);
    chk("single tx_dlc", 64'(tx_dlc), 64'd8);
    chk("single tx_data", tx_data, 64'h0011_2233_4455_6677);
    tick();
    chk("single start width", 64'(tx_start), 64'd0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("single ack", 64'(mb_ack), 64'b0100);
    mb_req = '0;
    tick();
    chk("single ack width", 64'(mb_ack), 64'd0);
    tick();
    chk("single busy in gap", 64'(sched_busy), 64'd1);
    chk("single tx_id stable", 64'(tx_id), 64'h123);
    tick();
    chk("single idle after gap", 64'(sched_busy), 64'd0);
    dlc_a[2] = 4'd7; data_a[2] = {32'hC0DE_0002, 32'h1234_5678 ^ 32'd14};

    // Priority vector table
    tbl[0] = '{req: 4'b1011, id: {11'h050, 11'h000, 11'h050, 11'h300},
               order: {3'd0, 3'd0, 3'd3, 3'd1}, n: 3};
    tbl[1] = '{req: 4'b1111, id: {11'h001, 11'h400, 11'h000, 11'h7FF},
               order: {3'd0, 3'd2, 3'd3, 3'd1}, n: 4};
    tbl[2] = '{req: 4'b0110, id: {11'h123, 11'h123, 11'h123, 11'h123},
               order: {3'd0, 3'd0, 3'd2, 3'd1}, n: 2};
    tbl[3] = '{req: 4'b1000, id: {11'h7FF, 11'h000, 11'h000, 11'h000},
               order: {3'd0, 3'd0, 3'd0, 3'd3}, n: 1};
    tbl[4] = '{req: 4'b1111, id: {11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF},
               order: {3'd3, 3'd2, 3'd1, 3'd0}, n: 4};
    for (int r = 0; r < 5; r++) begin
      id_a   = tbl[r].id;
      mb_req = tbl[r].req;
      for (int k = 0; k < tbl[r].n; k++) begin
        w = int'(tbl[r].order[k]);
        wait_start("table", ok);
        if (!ok) break;
        chk("table cur_mb", 64'(cur_mb), 64'(w));
        chk("table tx_id", 64'(tx_id), 64'(id_a[w]));
        chk("table tx_dlc", 64'(tx_dlc), 64'(dlc_a[w]));
        chk("table tx_data", tx_data, data_a[w]);
        ev(1'b1, 1'b0, 1'b0, 4'(1 << w), 4'b0000, 0, "table");
      end
      mb_req = '0;
      wait_idle("table");
    end

    // Bus not idle and spurious node events hold the scheduler in IDLE
    bus_idle = 1'b0;
    id_a[0] = 11'h055;
    mb_req = 4'b0001;
    tx_done = 1'b1; tx_err = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    tx_done = 1'b0; tx_err = 1'b0;
    chk("bus busy hold", 64'({sched_busy, tx_start}), 64'd0);
    chk("spurious ack", 64'({mb_ack, mb_fail}), 64'd0);
    bus_idle = 1'b1;
    wait_start("bus_idle release", ok);
    chk("bus_idle cur_mb", 64'(cur_mb), 64'd0);
    ev(1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000, 1, "bus_idle");
    wait_idle("bus_idle");

    // Ten arbitration losses then success
    starts = 0;
    id_a[0] = 11'h0AA;
    mb_req = 4'b0001;
    for (int k = 0; k < 11; k++) begin
      wait_start("arb", ok);
      if (!ok) break;
      starts++;
      if (k < 10) ev(1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, k % 3, "arb lost");
      else        ev(1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000, 0, "arb done");
    end
    chk("arb start count", 64'(starts), 64'd11);
    wait_idle("arb");

    // Retry exhaustion: four attempts then fail, no further start
    id_a[1] = 11'h111;
    mb_req = 4'b0010;
    for (int k = 0; k <= MAXR; k++) begin
      wait_start("retry", ok);
      if (!ok) break;
      ev(1'b0, 1'b1, 1'b0, 4'b0000, (k == MAXR) ? 4'b0010 : 4'b0000, 0, "retry err");
    end
    starts = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (tx_start) starts++;
    end
    chk("retry no restart", 64'(starts), 64'd0);

    // Done and error together: ack wins and the retry count stays clear
    id_a[0] = 11'h321;
    mb_req = 4'b0001;
    wait_start("done+err", ok);
    ev(1'b1, 1'b1, 1'b1, 4'b0001, 4'b0000, 0, "done+err");
    mb_req = 4'b0001;
    for (int k = 0; k <= MAXR; k++) begin
      wait_start("post done+err", ok);
      if (!ok) break;
      ev(1'b0, 1'b1, 1'b0, 4'b0000, (k == MAXR) ? 4'b0001 : 4'b0000, 0, "post done+err");
    end
    wait_idle("done+err");

    // Preemption after an error restarts the preempted frame's retry budget
    id_a[2] = 11'h200; id_a[3] = 11'h010;
    mb_req = 4'b0100;
    wait_start("preempt first", ok);
    chk("preempt first cur_mb", 64'(cur_mb), 64'd2);
    ev(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 0, "preempt err");
    mb_req = 4'b1100;
    wait_start("preempt newcomer", ok);
    chk("preempt newcomer cur_mb", 64'(cur_mb), 64'd3);
    chk("preempt newcomer tx_id", 64'(tx_id), 64'h010);
    ev(1'b1, 1'b0, 1'b0, 4'b1000, 4'b0000, 0, "preempt done");
    for (int k = 0; k <= MAXR; k++) begin
      wait_start("preempt retry", ok);
      if (!ok) break;
      chk("preempt retry cur_mb", 64'(cur_mb), 64'd2);
      ev(1'b0, 1'b1, 1'b0, 4'b0000, (k == MAXR) ? 4'b0100 : 4'b0000, 0, "preempt retry");
    end
    wait_idle("preempt");

    // Reset during WAIT, with a done event arriving in the reset cycle
    id_a[1] = 11'h0F0;
    mb_req = 4'b0010;
    wait_start("rst mid", ok);
    tick();
    RST_N = 1'b0; tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk_zero_outputs("rst mid");
    tick();
    chk("rst mid no pulse", 64'({mb_ack, mb_fail}), 64'd0);
    RST_N = 1'b1;
    wait_start("rst restart", ok);
    chk("rst restart cur_mb", 64'(cur_mb), 64'd1);
    chk("rst restart tx_id", 64'(tx_id), 64'h0F0);
    ev(1'b1, 1'b0, 1'b0, 4'b0010, 4'b0000, 0, "rst restart");
    wait_idle("rst restart");

    // Randomized run against the transaction-level model
    do_reset();
    last_mb = 0;
    errs    = 0;
    for (int it = 0; it < 200; it++) begin
      if (mb_req == '0) begin
        for (int i = 0; i < NMB; i++) begin
          if ($urandom_range(0, 1) == 1 || (i == NMB - 1 && mb_req == '0)) begin
            case ($urandom_range(0, 3))
              0:       id_a[i] = 11'h000;
              1:       id_a[i] = 11'h7FF;
              default: id_a[i] = 11'($urandom_range(0, 7));
            endcase
            dlc_a[i]  = 4'($urandom_range(0, 15));
            data_a[i] = {32'($urandom), 32'($urandom)};
            mb_req[i] = 1'b1;
          end
        end
      end
      wait_start("rnd", ok);
      if (!ok) break;
      best = -1;
      for (int i = 0; i < NMB; i++) begin
        if (mb_req[i] && (best < 0 || int'(id_a[i]) * NMB + i < int'(id_a[best]) * NMB + best))
          best = i;
      end
      w = best;
      chk("rnd cur_mb", 64'(cur_mb), 64'(w));
      chk("rnd tx_id", 64'(tx_id), 64'(id_a[w]));
      chk("rnd tx_dlc", 64'(tx_dlc), 64'(dlc_a[w]));
      chk("rnd tx_data", tx_data, data_a[w]);
      if (w != last_mb) errs = 0;
      last_mb = w;
      if ($urandom_range(0, 2) == 0) begin
        for (int i = 0; i < NMB; i++) begin
          if (!mb_req[i] && $urandom_range(0, 1) == 1) begin
            id_a[i]   = 11'($urandom_range(0, 2047));
            dlc_a[i]  = 4'($urandom_range(0, 15));
            data_a[i] = {32'($urandom), 32'($urandom)};
            mb_req[i] = 1'b1;
          end
        end
      end
      d = 1'b0; e = 1'b0; a = 1'b0;
      case ($urandom_range(0, 6))
        0, 1: d = 1'b1;
        2, 3: e = 1'b1;
        4:    a = 1'b1;
        5:    begin d = 1'b1; e = 1'b1; end
        default: begin e = 1'b1; a = 1'b1; end
      endcase
      eack = '0; efail = '0;
      if (d) begin
        eack[w] = 1'b1;
        errs = 0;
      end else if (e) begin
        if (errs < MAXR) errs++;
        else begin
          efail[w] = 1'b1;
          errs = 0;
        end
      end
      ev(d, e, a, eack, efail, $urandom_range(0, 3), "rnd");
    end
    mb_req = '0;
    wait_idle("rnd end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
